// File: rtl/bitcell_pkg.sv
// Shared definitions for the bitcell leaf cell and the arrays built from it.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package bitcell_pkg;

    // Encoding of the r_w pin.
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Decoded operation of a cell in a given cycle.
    typedef enum logic [1:0] {
        OP_ST_IDLE  = 2'd0,
        OP_ST_READ  = 2'd1,
        OP_ST_WRITE = 2'd2
    } bitcell_op_e;

endpackage

// File: rtl/bitcell_nand_store.sv
// Storage register for one cell: WIDTH bits, async reset to RESET_VAL, write-enable.
// Latency: a write appears on q one cycle after the enabling edge.
// Backpressure: none; a write is accepted on every enabled edge.
module bitcell_nand_store #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stored;

    // Capture write data on enabled edges; reset forces a defined value immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stored <= RESET_VAL;
        end else if (i_we) begin
            r_stored <= i_d;
        end
    end

    assign o_q = r_stored;

endmodule

// File: rtl/bitcell_nand.sv
// Clocked NAND-latch style memory bitcell with word-line select and wired-OR friendly read port.
// Latency: write 1 cycle; read 0 cycles (1 cycle when BITCELL_NAND_READ_REG_EN is defined).
// Backpressure: none; out drives zero whenever the cell is not being read.
import bitcell_pkg::*;

module bitcell_nand #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_w,
    input  logic             sel,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] latch_nand1_out
);

    bitcell_op_e      w_op;
    logic             w_we;
    logic             w_rd;
    logic [WIDTH-1:0] w_q;

    // Decode word-line and r_w into this cycle's operation.
    always_comb begin
        w_op = OP_ST_IDLE;
        if (sel) begin
            if (r_w == OP_WRITE) begin
                w_op = OP_ST_WRITE;
            end else if (r_w == OP_READ) begin
                w_op = OP_ST_READ;
            end
        end
    end

    assign w_we = (w_op == OP_ST_WRITE);
    // Reset also silences the read port so a shared bit-line stays quiet.
    assign w_rd = (w_op == OP_ST_READ) && rst_n;

    bitcell_nand_store #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (w_we),
        .i_d   (in),
        .o_q   (w_q)
    );

    assign latch_nand1_out = w_q;

`ifdef BITCELL_NAND_READ_REG_EN
    logic [WIDTH-1:0] r_out;

    // Registered read port: sample the gated stored value each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_rd ? w_q : '0;
        end
    end

    assign out = r_out;
`else
    // Combinational read port: only drives while selected for read.
    assign out = w_rd ? w_q : '0;
`endif

endmodule

// File: tb/tb_bitcell_nand.sv
// Directed plus randomized checks of bitcell_nand against a behavioural cell model.
// Latency: model tracks write at the edge and read per build option.
// Backpressure: not applicable.
module tb_bitcell_nand;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         r_w;
    logic         sel;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] q;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: the value held by the cell and the registered read value.
    logic [W-1:0] m_store;
    logic [W-1:0] m_out_reg;

    always #5 clk = ~clk;

    bitcell_nand #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .r_w             (r_w),
        .sel             (sel),
        .in              (din),
        .out             (dout),
        .latch_nand1_out (q)
    );

    function automatic logic [W-1:0] exp_out();
`ifdef BITCELL_NAND_READ_REG_EN
        return m_out_reg;
`else
        return (rst_n && sel && !r_w) ? m_store : '0;
`endif
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of operation: drive at negedge, check, update model at posedge, check.
    task automatic cycle(input logic s, input logic rw, input logic [W-1:0] d, input string tag);
        @(negedge clk);
        sel = s; r_w = rw; din = d;
        #1;
        check({tag, "_out"}, dout, exp_out());
        check({tag, "_q"}, q, m_store);
        @(posedge clk);
        m_out_reg = (rst_n && s && !rw) ? m_store : '0;
        if (s && rw) m_store = d;
        #1;
        check({tag, "_qpost"}, q, m_store);
    endtask

    initial begin
        // Reset held while a write is attempted across several edges.
        rst_n = 1'b0; sel = 1'b1; r_w = 1'b1; din = 8'hFF;
        m_store = '0; m_out_reg = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            din = ~din;
            check("reset_q", q, 8'h00);
            check("reset_out", dout, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1; sel = 1'b0;

        // Idle immunity for every (r_w, in) combination.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 10; i++) begin
                cycle(1'b0, (c % 2 == 0), (c >= 2) ? 8'hFF : 8'h00, "idle");
            end
        end

        // Write 0, read it, change in during read.
        cycle(1'b1, 1'b1, 8'h00, "wr0");
        cycle(1'b1, 1'b0, 8'h00, "rd0");
        cycle(1'b1, 1'b0, 8'h01, "rd0_inchg");
        cycle(1'b1, 1'b0, 8'h01, "rd0_hold");

        // Write 1, read it, change in during read.
        cycle(1'b1, 1'b1, 8'h01, "wr1");
        cycle(1'b1, 1'b0, 8'h01, "rd1");
        cycle(1'b1, 1'b0, 8'h00, "rd1_inchg");
        cycle(1'b0, 1'b0, 8'h00, "rd1_end");
        cycle(1'b0, 1'b0, 8'h00, "rd1_end2");

        // Full-width pattern, then unselected writes must not disturb it.
        cycle(1'b1, 1'b1, 8'hA5, "wrA5");
        cycle(1'b1, 1'b0, 8'h00, "rdA5");
        cycle(1'b1, 1'b0, 8'h00, "rdA5b");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hFF, "unsel_wr");
        check("A5_kept", q, 8'hA5);
        cycle(1'b1, 1'b0, 8'h00, "rdA5c");

        // Reset asserted mid-read, away from any clock edge.
        @(negedge clk);
        sel = 1'b1; r_w = 1'b0; din = 8'h00;
        #2;
        rst_n = 1'b0;
        m_store = '0; m_out_reg = '0;
        #1;
        check("midrst_out", dout, 8'h00);
        check("midrst_q", q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h00, "postrst_rd");

        // Randomized operations against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitcell_nand.md
Name: bitcell_nand

Overview:
- Single addressable memory bitcell, vectorised to WIDTH bits: a storage element plus read/write gating.
- Models the NAND-latch SRAM-style cell as a synchronous, clocked equivalent for use as the leaf cell of small register-file/memory arrays.
- sel acts as the word-line; r_w selects write (1) or read (0).
- The stored value is always visible on a debug/observe port.

Parameters:
- WIDTH, 1, number of bits stored in the cell; all data ports are WIDTH wide.
- RESET_VAL, 0 (WIDTH bits), value loaded into storage on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- r_w  input  1  operation select: 1 = write, 0 = read.
- sel  input  1  cell select (word-line); no operation when 0.
- in  input  WIDTH  write data.
- out  output  WIDTH  read data.
- latch_nand1_out  output  WIDTH  current stored value (always visible, independent of sel/r_w).

Behaviour:
- Storage register "stored", WIDTH bits.
- rst_n low: stored = RESET_VAL immediately (asynchronous), independent of clk. out = 0 and latch_nand1_out = RESET_VAL while reset is held.
- Write: sel=1 and r_w=1 at a rising clk edge, so stored <= in. latch_nand1_out shows the new value after that edge (1-cycle latency).
- Read: sel=1 and r_w=0, so out = stored, combinationally (0-cycle latency). in is ignored.
- Idle: sel=0, so stored holds regardless of r_w and in, and out = 0.
- During a write cycle, out = 0. The output drives only on read, so the cell can share a wired-OR bit-line.
- out = {WIDTH{sel & ~r_w}} & stored.
- Write-then-read in consecutive cycles: the read returns the value written in the previous cycle. There is no same-cycle write-through.
- Reset deassertion mid-operation: the first rising edge after rst_n goes high is treated as a normal cycle.
- No X propagation from storage: stored is always defined after reset.

Optional Feature:
- Macro: BITCELL_NAND_READ_REG_EN.
- Defined: out is registered. out <= (sel & ~r_w) ? stored : 0 at each rising clk edge, so read latency is 1 cycle. The out register resets asynchronously to 0.
- Undefined: out is combinational, as described above (0-cycle read latency).
- latch_nand1_out timing is unaffected in both cases.

Decomposition:
- Shared package bitcell_pkg:
  - constants OP_READ = 1'b0 and OP_WRITE = 1'b1 for r_w;
  - a typedef for the cell's op state (IDLE/READ/WRITE enum) used by benches and array wrappers.
- One natural sub-module: bitcell_nand_store.
  - Holds the WIDTH-bit storage register with asynchronous reset and write-enable.
  - Exposes q, which becomes latch_nand1_out.
- The top level contains the select/read gating and the optional output register.

Test Plan:
- Reset: rst_n=0 with sel=1, r_w=1, in=1 toggled across clock edges -> stored and latch_nand1_out stay 0; out=0.
- Idle immunity: after reset, sel=0 for each combination (r_w,in) in (1,0), (0,0), (1,1), (0,1), 10 cycles each -> latch_nand1_out=0 and out=0 throughout.
- Write 0 then read:
  - sel=1, r_w=1, in=0 for one edge -> latch_nand1_out=0.
  - Then sel=1, r_w=0, in=0 -> out=0.
  - Then in=1 while still reading -> out stays 0 and storage is unchanged.
- Write 1 then read:
  - sel=1, r_w=1, in=1 for one edge -> latch_nand1_out=1, and out=0 during the write.
  - Then sel=1, r_w=0, in=1 -> out=1.
  - Then in=0 while reading -> out stays 1.
- WIDTH=8:
  - Write 8'hA5 -> latch_nand1_out=8'hA5; a read gives out=8'hA5.
  - With sel=0, in=8'hFF, r_w=1 for 3 cycles -> value still 8'hA5 and out=0.
  - Assert rst_n low mid-read -> out=0 and latch_nand1_out=RESET_VAL immediately, without waiting for a clock edge.
- With BITCELL_NAND_READ_REG_EN: after writing 1, start a read -> out=0 in the first cycle and 1 from the next rising edge; ending the read returns out to 0 one cycle later.
